zeros_rnd_feeder: RTL and testbench
===================================

// Module: zeros_rnd_feeder
// PURPOSE
// - Masked-randomness source feeding the zero-sharing generator: delivers one (d-1)*Nbits-bit fresh random word per request.
// - 64-bit Fibonacci LFSR, seeded externally, advanced CHUNK steps per cycle into a fill buffer.
// - Word is handed over with a valid/ready handshake; the zero-sharing stage consumes it combinationally.
// PARAMETERS
// - d      2    masking order + 1 (number of shares)
// - Nbits  128  bits per share; output word RW=(d-1)*Nbits
// - CHUNK  32   fresh bits produced per cycle; RW%CHUNK==0 and 1<=CHUNK<=64 (elaboration error otherwise)
// - WARM   16   discard cycles after each (re)seed, >=1
// PORTS
// - clk         in   1     system clock, all state on rising edge
// - rst         in   1     synchronous, active-high reset
// - seed        in   64    LFSR seed
// - seed_valid  in   1     load seed this cycle (pulse)
// - rnd         out  RW    random word for zero sharing; stable while rnd_valid
// - rnd_valid   out  1     rnd holds a full, never-delivered word
// - rnd_ready   in   1     consumer takes rnd when rnd_valid&rnd_ready
// - busy        out  1     high in WARMUP or FILL
// - rnd_err     out  1     health failure flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset: state=UNSEEDED, lfsr=64'h0, rnd=0, rnd_valid=0, busy=0, rnd_err=0, counters=0.
// - LFSR: taps 64,63,61,60 (x^64+x^63+x^61+x^60+1); one step: fb=s[63]^s[62]^s[60]^s[59]; s<={s[62:0],fb}.
//   CHUNK steps unrolled per cycle; the CHUNK feedback bits, oldest first at LSB, form the chunk.
// - Seed load: lfsr<=seed; seed==0 is replaced by 64'h1 (no lock-up).
// - FSM:
//   UNSEEDED: wait; seed_valid -> WARMUP.
//   WARMUP: advance LFSR WARM cycles, discard output; then -> FILL, fill_cnt=0.
//   FILL: write chunk into rnd[fill_cnt*CHUNK +: CHUNK]; after RW/CHUNK cycles -> READY.
//   READY: rnd_valid=1; on rnd_valid&rnd_ready -> FILL (rnd_valid low next cycle); LFSR holds in READY.
// - Latency: seed_valid at T -> rnd_valid at T+1+WARM+RW/CHUNK; transfer at T -> next rnd_valid at T+1+RW/CHUNK.
// - Words never repeat delivery: one handshake per word; rnd_ready while !rnd_valid is ignored.
// - rnd changes only in FILL; partially filled word never visible as valid.
// - seed_valid has priority in any seeded state: reload, drop rnd_valid next cycle, -> WARMUP, fill_cnt=0.
//   A handshake in the same cycle still counts as accepted (word was valid that cycle).
// - rst mid-operation: returns to UNSEEDED; new seed required.
// - busy = (state==WARMUP)|(state==FILL).
// CONFIGURATION
// - ZEROS_RND_HEALTH_EN defined:
//   - rnd_err set (sticky) if a completed word equals the last delivered word, or the LFSR state is 0.
//   - While rnd_err: READY is not entered, rnd_valid stays 0; cleared by seed_valid or rst.
//   - Adds an RW-bit last-word register.
// - Not defined: rnd_err tied 0, no comparison logic or last-word register.
// TESTING (d=2, Nbits=128, CHUNK=32, WARM=16)
// - rst, then seed=64'h0123456789ABCDEF at T -> rnd_valid rises at T+21; rnd matches bit-accurate LFSR model.
// - Hold rnd_ready=0 for 50 cycles -> rnd_valid stays 1, rnd constant; pulse ready -> rnd_valid=0 for 4 cycles, new word.
// - Seed 64'h0 -> behaves identically to seed 64'h1 (same rnd words).
// - seed_valid during FILL (fill_cnt=2) -> no valid for 16+4 cycles; word equals fresh-seed model.
// - Back-to-back: rnd_ready=1 constantly -> one word every 5 cycles, no duplicates over 1000 words.
// - HEALTH_EN: force LFSR to 0 -> rnd_err=1, rnd_valid=0; seed 64'h5 -> rnd_err=0, resumes.

Source files
------------

// File: rtl/zeros_rnd_feeder.sv
// Masked-randomness source for the zero-sharing stage: a 64-bit Fibonacci LFSR fills RW-bit words CHUNK bits per cycle.
// Optional health monitor (repeat-word / LFSR lock-up detection) is enabled by defining ZEROS_RND_HEALTH_EN.
module zeros_rnd_feeder #(
  parameter int d     = 2,
  parameter int Nbits = 128,
  parameter int CHUNK = 32,
  parameter int WARM  = 16,
  localparam int RW   = (d - 1) * Nbits
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   seed,
  input  logic          seed_valid,
  output logic [RW-1:0] rnd,
  output logic          rnd_valid,
  input  logic          rnd_ready,
  output logic          busy,
  output logic          rnd_err
);

  // Handshake: a word moves on every rising edge where rnd_valid & rnd_ready;
  // rnd_valid never depends on rnd_ready and rnd is held stable while rnd_valid is high.

  localparam int NCH = RW / CHUNK;
  localparam int FW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW  = (WARM > 1) ? $clog2(WARM) : 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(NCH - 1);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARM - 1);

  generate
    if (CHUNK < 1 || CHUNK > 64 || (RW % CHUNK) != 0 || WARM < 1) begin : g_bad_cfg
      $error("zeros_rnd_feeder: illegal CHUNK/WARM/RW combination");
    end
  endgenerate

  typedef enum logic [1:0] {ST_UNSEEDED, ST_WARMUP, ST_FILL, ST_READY} state_t;

  state_t          state_q, state_d, state_pre;
  logic [63:0]     lfsr_q, lfsr_d, lfsr_adv;
  logic [RW-1:0]   rnd_q, rnd_d;
  logic [FW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [WW-1:0]   warm_cnt_q, warm_cnt_d;
  logic [CHUNK-1:0] chunk;

  // CHUNK unrolled LFSR steps; feedback bits land oldest-first at the LSB.
  always_comb begin : lfsr_unroll
    logic fb;
    fb       = 1'b0;
    lfsr_adv = lfsr_q;
    chunk    = '0;
    for (int i = 0; i < CHUNK; i++) begin
      fb       = lfsr_adv[63] ^ lfsr_adv[62] ^ lfsr_adv[60] ^ lfsr_adv[59];
      chunk[i] = fb;
      lfsr_adv = {lfsr_adv[62:0], fb};
    end
  end

  always_comb begin
    state_pre  = state_q;
    lfsr_d     = lfsr_q;
    rnd_d      = rnd_q;
    fill_cnt_d = fill_cnt_q;
    warm_cnt_d = warm_cnt_q;
    case (state_q)
      ST_WARMUP: begin
        lfsr_d = lfsr_adv;
        if (warm_cnt_q == WARM_LAST) begin
          state_pre  = ST_FILL;
          warm_cnt_d = '0;
          fill_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + WW'(1);
        end
      end
      ST_FILL: begin
        lfsr_d = lfsr_adv;
        for (int i = 0; i < NCH; i++) begin
          if (fill_cnt_q == FW'(i)) rnd_d[i*CHUNK +: CHUNK] = chunk;
        end
        if (fill_cnt_q == FILL_LAST) begin
          state_pre  = ST_READY;
          fill_cnt_d = '0;
        end else begin
          fill_cnt_d = fill_cnt_q + FW'(1);
        end
      end
      ST_READY: begin
        if (rnd_valid && rnd_ready) state_pre = ST_FILL;
      end
      default: ;
    endcase
    // A seed restarts warm-up from any state; an all-zero seed would lock the LFSR.
    if (seed_valid) begin
      lfsr_d     = (seed == 64'h0) ? 64'h1 : seed;
      state_pre  = ST_WARMUP;
      warm_cnt_d = '0;
      fill_cnt_d = '0;
    end
  end

`ifdef ZEROS_RND_HEALTH_EN
  logic          rnd_err_q, rnd_err_d;
  logic [RW-1:0] last_q, last_d;

  always_comb begin
    rnd_err_d = rnd_err_q;
    last_d    = last_q;
    if (rnd_valid && rnd_ready) last_d = rnd_q;
    if ((state_q == ST_FILL && fill_cnt_q == FILL_LAST && rnd_d == last_q) ||
        (state_q != ST_UNSEEDED && lfsr_q == 64'h0))
      rnd_err_d = 1'b1;
    if (seed_valid) rnd_err_d = 1'b0;
    // A failed source keeps refilling but never presents a word.
    state_d = state_pre;
    if (rnd_err_d && state_pre == ST_READY) state_d = ST_FILL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_err_q <= 1'b0;
      last_q    <= '0;
    end else begin
      rnd_err_q <= rnd_err_d;
      last_q    <= last_d;
    end
  end

  assign rnd_err   = rnd_err_q;
  assign rnd_valid = (state_q == ST_READY) && !rnd_err_q;
`else
  assign state_d   = state_pre;
  assign rnd_err   = 1'b0;
  assign rnd_valid = (state_q == ST_READY);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_UNSEEDED;
      lfsr_q     <= 64'h0;
      rnd_q      <= '0;
      fill_cnt_q <= '0;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      rnd_q      <= rnd_d;
      fill_cnt_q <= fill_cnt_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  assign rnd  = rnd_q;
  assign busy = (state_q == ST_WARMUP) || (state_q == ST_FILL);

endmodule

// File: tb/tb_zeros_rnd_feeder.sv
// Self-checking bench for zeros_rnd_feeder against a bit-serial LFSR reference model.
// Define ZEROS_RND_HEALTH_EN for both files to also exercise the health monitor.
module tb_zeros_rnd_feeder;
  localparam int D     = 2;
  localparam int NBITS = 128;
  localparam int CHUNK = 32;
  localparam int WARM  = 16;
  localparam int RW    = (D - 1) * NBITS;
  localparam int NCH   = RW / CHUNK;

  logic          clk = 1'b0;
  logic          rst, seed_valid, rnd_ready;
  logic [63:0]   seed;
  logic [RW-1:0] rnd;
  logic          rnd_valid, busy, rnd_err;

  int tests = 0;
  int fails = 0;
  logic [RW-1:0] exp_q[$];
  logic [63:0]   m_s;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  zeros_rnd_feeder #(.d(D), .Nbits(NBITS), .CHUNK(CHUNK), .WARM(WARM)) dut (
    .clk(clk), .rst(rst), .seed(seed), .seed_valid(seed_valid),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .busy(busy), .rnd_err(rnd_err)
  );

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=no_summary expected=finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // The word is simply the next RW feedback bits of the LFSR, first bit at bit 0.
  task automatic model_bit(output logic b);
    b   = m_s[63] ^ m_s[62] ^ m_s[60] ^ m_s[59];
    m_s = {m_s[62:0], b};
  endtask

  task automatic model_seed(input logic [63:0] s);
    logic b;
    exp_q.delete();
    m_s = s;
    repeat (WARM * CHUNK) model_bit(b);
  endtask

  task automatic model_push();
    logic [RW-1:0] w;
    logic b;
    for (int i = 0; i < RW; i++) begin
      model_bit(b);
      w[i] = b;
    end
    exp_q.push_back(w);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load_seed(input logic [63:0] s);
    seed       = s;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
  endtask

  // Ticks until rnd_valid is seen (bounded); jitter wiggles rnd_ready while no word is offered.
  task automatic wait_valid(output int n, input bit jitter);
    n = 0;
    while (rnd_valid !== 1'b1 && n < 300) begin
      if (jitter) rnd_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (jitter) rnd_ready = 1'b0;
  endtask

  task automatic take_word(input string tag);
    logic [RW-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_valid"}, RW'(rnd_valid), RW'(1));
    check({tag, "_word"}, rnd, e);
  endtask

  task automatic handshake();
    rnd_ready = 1'b1;
    tick();
    rnd_ready = 1'b0;
  endtask

  // ---------------- directed + randomized sequence ----------------
  initial begin
    int n, stable, hold;
    logic [63:0] s;
    logic [RW-1:0] w, prev;

    rst = 1'b1; seed_valid = 1'b0; rnd_ready = 1'b0; seed = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_valid", RW'(rnd_valid), RW'(0));
    check("rst_busy", RW'(busy), RW'(0));
    check("rst_err", RW'(rnd_err), RW'(0));
    check("rst_rnd", rnd, '0);
    repeat (5) tick();
    check("unseeded_idle", RW'(rnd_valid | busy), RW'(0));

    // First word after seeding: latency and bit-exact content.
    model_seed(64'h0123456789ABCDEF);
    model_push();
    load_seed(64'h0123456789ABCDEF);
    check("seed_busy", RW'(busy), RW'(1));
    wait_valid(n, 1'b0);
    check("seed_latency", RW'(n), RW'(WARM + NCH - 1 + 1));
    check("ready_busy", RW'(busy), RW'(0));
    take_word("w0");

    // Back-pressure: word held stable for 50 cycles.
    w = rnd;
    stable = 0;
    repeat (50) begin
      tick();
      if (rnd_valid === 1'b1 && rnd === w) stable++;
    end
    check("hold_stable", RW'(stable), RW'(50));
    model_push();
    handshake();
    check("after_take_valid", RW'(rnd_valid), RW'(0));
    wait_valid(n, 1'b0);
    check("refill_latency", RW'(n), RW'(NCH));
    take_word("w1");

    // Seed 0 must behave exactly like seed 1.
    model_seed(64'h1);
    model_push();
    model_push();
    load_seed(64'h0);
    wait_valid(n, 1'b0);
    check("seed0_latency", RW'(n), RW'(WARM + NCH));
    take_word("seed0_a");
    handshake();
    wait_valid(n, 1'b0);
    take_word("seed0_b");

    // Reseed in the middle of a fill (third chunk being written).
    handshake();
    tick();
    tick();
    s = {$urandom, $urandom} | 64'h100;
    model_seed(s);
    model_push();
    load_seed(s);
    check("reseed_valid", RW'(rnd_valid), RW'(0));
    wait_valid(n, 1'b0);
    check("reseed_latency", RW'(n), RW'(WARM + NCH));
    take_word("reseed");

    // Reset mid-fill returns to the unseeded state.
    handshake();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", RW'({rnd_valid, busy, rnd_err}), RW'(0));
    check("midrst_rnd", rnd, '0);
    stable = 0;
    repeat (30) begin
      rnd_ready = 1'($urandom_range(0, 1));
      tick();
      if (rnd_valid !== 1'b0 || busy !== 1'b0) stable++;
    end
    rnd_ready = 1'b0;
    check("midrst_no_word", RW'(stable), RW'(0));

    // Randomized ready timing, with stray ready pulses while no word is offered.
    s = {$urandom, $urandom} | 64'h100;
    model_seed(s);
    load_seed(s);
    for (int k = 0; k < 40; k++) begin
      model_push();
      wait_valid(n, 1'b1);
      check("rand_latency", RW'(n), RW'((k == 0) ? WARM + NCH : NCH));
      take_word("rand");
      w = rnd;
      hold = $urandom_range(0, 6);
      stable = 0;
      repeat (hold) begin
        tick();
        if (rnd_valid === 1'b1 && rnd === w) stable++;
      end
      check("rand_hold", RW'(stable), RW'(hold));
      handshake();
    end

    // Continuous ready: one new word every NCH+1 cycles, none repeated.
    rnd_ready = 1'b1;
    model_push();
    wait_valid(n, 1'b0);
    check("b2b_first", RW'(n), RW'(NCH));
    prev = '0;
    for (int k = 0; k < 1000; k++) begin
      take_word("b2b");
      check("b2b_fresh", RW'(rnd !== prev), RW'(1));
      prev = rnd;
      model_push();
      tick();
      wait_valid(n, 1'b0);
      check("b2b_period", RW'(n), RW'(NCH));
    end
    rnd_ready = 1'b0;
    take_word("b2b_last");

`ifdef ZEROS_RND_HEALTH_EN
    // LFSR lock-up raises the sticky error and suppresses words until reseeded.
    handshake();
    force dut.lfsr_q = 64'h0;
    tick();
    tick();
    release dut.lfsr_q;
    check("health_err", RW'(rnd_err), RW'(1));
    stable = 0;
    repeat (20) begin
      tick();
      if (rnd_valid !== 1'b0) stable++;
    end
    check("health_no_word", RW'(stable), RW'(0));
    check("health_sticky", RW'(rnd_err), RW'(1));
    model_seed(64'h5);
    model_push();
    load_seed(64'h5);
    check("health_clear", RW'(rnd_err), RW'(0));
    wait_valid(n, 1'b0);
    check("health_latency", RW'(n), RW'(WARM + NCH));
    take_word("health_resume");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
